// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_scan_ctrl
// Description : Scan controller for a four-digit multiplexed seven-segment
//               display. Produces the digit index for the downstream 4:1
//               digit multiplexer and the matching active-low anode enables.
//               Each digit occupies a slot of DIV clocks, and the first BLANK
//               clocks of every slot are dead time. Masked digits are skipped,
//               and a one-cycle pulse marks each wrap of the scan frame.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   en         in   1  scan enable; low freezes the scan and blanks all anodes
//   digit_mask in   4  bit i set = digit i takes part in the scan
//   sel        out  2  digit index to the digit multiplexer (registered)
//   an         out  4  active-low anode enables (combinational decode)
//   frame_done out  1  one-cycle pulse when the scan wraps (registered)
//
// Parameters:
//   DIV    clocks per digit slot (2..65535)
//   BLANK  dead-time clocks at the start of each slot (0..DIV-1)
//   CW     slot counter width, 2**CW >= DIV
//
// Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
    parameter int DIV   = 8,
    parameter int BLANK = 2,
    parameter int CW    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam logic [CW-1:0] c_cnt_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_sel;
    logic          r_frame_done;

    logic          w_slot_end;
    logic [1:0]    w_next_sel;
    logic [1:0]    w_idx;
    logic          w_found;
    logic          w_wrap;
    logic          w_in_blank;
    logic          w_blank;

    assign w_slot_end = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------------
    // Next digit search: first enabled digit in the order sel+1, sel+2,
    // sel+3, sel. The final candidate is the current digit itself, so a
    // single enabled digit keeps its index. With no digit enabled nothing is
    // found, and the index holds.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_sel = r_sel;
        w_found    = 1'b0;
        w_idx      = r_sel;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_sel + 2'(k);
            if (!w_found && digit_mask[w_idx]) begin
                w_next_sel = w_idx;
                w_found    = 1'b1;
            end
        end
    end

    // The index moving to a value not above the old one means the scan has
    // passed the top digit. This includes the single-digit case.
    assign w_wrap = w_found && (w_next_sel <= r_sel);

    // ------------------------------------------------------------------------
    // Slot counter, digit index and frame pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_sel        <= 2'd0;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            // Freeze the scan position; the pulse must not stretch.
            r_frame_done <= 1'b0;
        end else if (w_slot_end) begin
            r_cnt        <= '0;
            r_sel        <= w_next_sel;
            r_frame_done <= w_wrap;
        end else begin
            r_cnt        <= r_cnt + CW'(1);
            r_frame_done <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Dead time at the start of each slot. The index changes only when the
    // counter returns to zero, so with BLANK >= 1 the anodes are always off
    // while the multiplexer output settles.
    // ------------------------------------------------------------------------
    generate
        if (BLANK == 0) begin : g_no_dead_time
            assign w_in_blank = 1'b0;
        end else begin : g_dead_time
            assign w_in_blank = (r_cnt < CW'(BLANK));
        end
    endgenerate

    // The mask is used live here, so clearing the current digit's bit
    // blanks it right away and does not wait for the slot to end.
    assign w_blank = !en || w_in_blank || !digit_mask[r_sel];

    assign an         = w_blank ? 4'b1111 : ~(4'b0001 << r_sel);
    assign sel        = r_sel;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_scan_ctrl
// Description : Self-checking bench for digit_scan_ctrl. Two instances run on
//               shared stimulus: DIV=8/BLANK=2 and DIV=8/BLANK=0. A
//               behavioural scan model predicts sel, an and frame_done for
//               each instance from the scanning rules. Directed scenarios are
//               followed by randomized enable, mask and reset traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_ctrl;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] digit_mask;

    logic [1:0] sel_a, sel_b;
    logic [3:0] an_a, an_b;
    logic       fd_a, fd_b;

    int vectors    = 0;
    int miscompares = 0;

    // model state per instance: index 0 -> BLANK=2, index 1 -> BLANK=0
    int m_cnt [2];
    int m_sel [2];
    bit m_fd  [2];
    int m_blank [2] = '{2, 0};

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV(DIV), .BLANK(2), .CW(16)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel_a),
        .an         (an_a),
        .frame_done (fd_a)
    );

    digit_scan_ctrl #(.DIV(DIV), .BLANK(0), .CW(16)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel_b),
        .an         (an_b),
        .frame_done (fd_b)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference scan: a slot lasts DIV clocks, after which
    // the scan moves to the next enabled digit (cyclic search ending on the
    // current digit). A pulse follows an advance that did not move upward.
    task automatic model_clock(input int i, input logic r, input logic e, input logic [3:0] m);
        int  nxt;
        bit  found;
        if (r) begin
            m_cnt[i] = 0;
            m_sel[i] = 0;
            m_fd[i]  = 0;
        end else if (!e) begin
            m_fd[i] = 0;
        end else if (m_cnt[i] == DIV - 1) begin
            found = 0;
            nxt   = m_sel[i];
            for (int k = 1; k <= 4; k++) begin
                if (!found && m[(m_sel[i] + k) % 4]) begin
                    nxt   = (m_sel[i] + k) % 4;
                    found = 1;
                end
            end
            m_fd[i]  = found && (nxt <= m_sel[i]);
            m_sel[i] = nxt;
            m_cnt[i] = 0;
        end else begin
            m_cnt[i] = m_cnt[i] + 1;
            m_fd[i]  = 0;
        end
    endtask

    function automatic logic [3:0] model_an(input int i, input logic e, input logic [3:0] m);
        if (!e || m_cnt[i] < m_blank[i] || !m[m_sel[i]])
            return 4'b1111;
        return 4'b1111 ^ (4'b0001 << m_sel[i]);
    endfunction

    task automatic step(input logic r, input logic e, input logic [3:0] m);
        rst        = r;
        en         = e;
        digit_mask = m;
        @(posedge clk);
        model_clock(0, r, e, m);
        model_clock(1, r, e, m);
        #1;
        chk("sel_blank2",   {2'b00, sel_a},   4'(m_sel[0]));
        chk("an_blank2",    an_a,             model_an(0, e, m));
        chk("fdone_blank2", {3'b000, fd_a},   {3'b000, m_fd[0]});
        chk("sel_blank0",   {2'b00, sel_b},   4'(m_sel[1]));
        chk("an_blank0",    an_b,             model_an(1, e, m));
        chk("fdone_blank0", {3'b000, fd_b},   {3'b000, m_fd[1]});
    endtask

    task automatic run(input int n, input logic e, input logic [3:0] m);
        for (int c = 0; c < n; c++) step(1'b0, e, m);
    endtask

    initial begin
        logic       r_r;
        logic       r_e;
        logic [3:0] r_m;

        rst        = 1'b1;
        en         = 1'b0;
        digit_mask = 4'b0000;
        m_cnt = '{0, 0};
        m_sel = '{0, 0};
        m_fd  = '{0, 0};

        // reset state, checked against fixed values too
        step(1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b1, 4'b1111);
        chk("rst_sel",   {2'b00, sel_a}, 4'h0);
        chk("rst_an",    an_a,           4'hF);
        chk("rst_fdone", {3'b000, fd_a}, 4'h0);

        // full four-digit scan
        run(70, 1'b1, 4'b1111);

        // alternate digits 1 and 3; digit 0 slot fully blank
        step(1'b1, 1'b1, 4'b1010);
        run(50, 1'b1, 4'b1010);

        // pause at sel=2, cnt=4 for 5 cycles
        step(1'b1, 1'b1, 4'b1111);
        run(20, 1'b1, 4'b1111);
        chk("pause_sel", {2'b00, sel_a}, 4'h2);
        run(5, 1'b0, 4'b1111);
        run(12, 1'b1, 4'b1111);

        // clear bit 1 at sel=1, cnt=3
        step(1'b1, 1'b1, 4'b1111);
        run(11, 1'b1, 4'b1111);
        run(25, 1'b1, 4'b1101);

        // reset at sel=3, cnt=5
        step(1'b1, 1'b1, 4'b1111);
        run(29, 1'b1, 4'b1111);
        chk("pre_rst_sel", {2'b00, sel_a}, 4'h3);
        step(1'b1, 1'b1, 4'b1111);
        chk("post_rst_an", an_a, 4'hF);
        run(20, 1'b1, 4'b1111);

        // nothing enabled
        run(40, 1'b1, 4'b0000);

        // single digit: pulse every slot
        run(30, 1'b1, 4'b0100);

        // randomized traffic
        r_m = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            r_r = ($urandom_range(0, 99) == 0);
            r_e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0)
                r_m = 4'($urandom_range(0, 15));
            step(r_r, r_e, r_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
